imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
Instruction-side front end that feeds IR to the single-cycle MIPS core.
- After reset, accepts a byte stream over a valid/ready handshake and assembles it into little-endian 32-bit words in an internal instruction array.
- Holds the core in reset while loading. Once loading finishes, releases the core and serves IR combinationally from IR_addr.

Parameters:
DEPTH, 256, number of 32-bit instruction words (power of 2, 4..1024)
AW, 8, word-index width = log2(DEPTH)

Ports:
clk  input  1  system clock, all state updates on posedge
rst_n  input  1  synchronous active-low reset
byte_in  input  8  load-stream data byte
byte_valid  input  1  byte_in valid
byte_last  input  1  qualifies final payload byte, sampled with byte_valid
byte_ready  output  1  loader accepts byte this cycle
IR_addr  input  32  core program counter (byte address)
IR  output  32  instruction word to core
core_rst_n  output  1  active-low reset to core, registered
word_count  output  AW+1  number of words loaded
load_err  output  1  sticky load error

Behaviour:
- Reset is synchronous, sampled on posedge clk when rst_n=0.
- Reset values:
  - state=LOAD, byte_ready=0 during reset, then 1 from the first cycle after rst_n=1.
  - core_rst_n=0, word_count=0, load_err=0, byte lane counter=0, assembly register=0.
  - Array contents are not cleared.
- Handshake: a byte is accepted on posedge when byte_valid & byte_ready. byte_in, byte_valid and byte_last may change only after acceptance; no combinational path from byte_valid to byte_ready.
- States: LOAD, [CKSUM], RUN, ERR.
- LOAD:
  - byte_ready=1.
  - Accepted byte k of the current word goes into bits [8k+7:8k] (lane 0 first, little-endian).
  - On acceptance of lane 3, or of any lane with byte_last=1: the word (unfilled upper lanes = 0) is written to array[word_count], word_count increments, and the lane counter returns to 0. The write is visible on IR from the next cycle.
  - byte_last=1 -> RUN (or CKSUM when the optional feature is enabled).
  - A byte accepted while word_count==DEPTH -> ERR, load_err=1, no write.
- RUN:
  - byte_ready=0.
  - core_rst_n=1 from the first cycle in RUN (registered, so one cycle after the transition edge).
  - Stays in RUN until rst_n.
- ERR:
  - byte_ready=1; the stream is drained and bytes are discarded.
  - core_rst_n stays 0 and load_err stays 1 until rst_n.
- IR read is combinational:
  - idx = IR_addr[AW+1:2]; IR_addr[1:0] is ignored.
  - IR = array[idx] if idx < word_count and IR_addr[31:AW+2]==0; otherwise 32'h0 (sll $0 = NOP).
  - During LOAD, IR reflects only words already written.
- Boundaries:
  - byte_last on lane 0 with DEPTH words already loaded -> ERR.
  - Zero-length load is not possible; the first accepted byte always starts word 0.
  - Reset mid-load: abandons the partial word and restarts at word 0. Stale array words are masked by word_count.

Optional Feature:
Macro IMEM_LOAD_CHECKSUM_EN.
- Defined:
  - A running XOR of all accepted payload bytes is kept (reset 8'h00).
  - After byte_last, state CKSUM accepts exactly one byte.
  - Byte equal to the running XOR -> RUN. Unequal -> ERR, load_err=1.
- Undefined: no CKSUM state; byte_last goes directly to RUN.

Decomposition:
- Shared package holds:
  - state encoding constants (ST_LOAD, ST_CKSUM, ST_RUN, ST_ERR);
  - NOP word constant 32'h0000_0000;
  - default DEPTH.
- One sub-module, imem_array: DEPTH x 32 storage with one synchronous write port and one asynchronous read port.
- The FSM, byte assembly and checksum stay in the top.

Test Plan:
- Stream 8 bytes 13 00 08 20 / 2A 00 09 20, last on byte 8 -> word0=20080013, word1=2009002A, word_count=2. core_rst_n rises the cycle after the last-byte edge; IR_addr=4 gives IR=2009002A, IR_addr=8 gives IR=0.
- 5 bytes AA BB CC DD 11, last on 11 -> word1=00000011, word_count=2, RUN.
- With DEPTH=4, stream 17 bytes without last -> after the 17th byte load_err=1, byte_ready stays 1, core_rst_n=0, word_count=4.
- Assert rst_n=0 after 6 bytes, then load 4 new bytes with last -> word_count=1. IR_addr=4 returns 0 despite the stale array content.
- Hold byte_valid with byte_ready toggled via reset; verify no byte is accepted during rst_n=0 and none in RUN (byte_ready=0).
- IMEM_LOAD_CHECKSUM_EN: payload 01 02 04 08 + cksum 0F -> RUN. Same payload + cksum 0E -> ERR, load_err=1.

Source files
------------

// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
package imem_boot_loader_pkg;

  localparam int DEFAULT_DEPTH = 256;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_CKSUM = 2'd1,
    ST_RUN   = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

endpackage

// File: rtl/imem_array.sv
// DEPTH x 32 instruction storage: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset; the loader masks stale words with its word count.
module imem_array #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_boot_loader.sv
// Instruction-side boot loader: assembles a little-endian byte stream into
// 32-bit words, holds the core in reset while loading, then serves IR.
// Optional load checksum byte enabled by defining IMEM_LOAD_CHECKSUM_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_LOAD  | accepting payload bytes, writing completed words
// ST_CKSUM | waiting for the single checksum byte (optional feature)
// ST_RUN   | load complete, core released, stream not accepted
// ST_ERR   | overflow or checksum mismatch, stream drained, core held
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    byte_in,
  input  logic          byte_valid,
  input  logic          byte_last,
  output logic          byte_ready,
  input  logic [31:0]   IR_addr,
  output logic [31:0]   IR,
  output logic          core_rst_n,
  output logic [AW:0]   word_count,
  output logic          load_err
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  state_t      state_q, state_d;
  logic        ready_q, core_q;
  logic        err_q, err_d;
  logic [AW:0] wc_q, wc_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] asm_q, asm_d, word_d;
  logic        we;
  logic        accept;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [7:0]  cks_q, cks_d;
`endif

  logic [AW-1:0] rd_idx;
  logic [31:0]   rd_word;
  logic          hi_zero;
  logic          unused_addr_bits;

  assign accept = byte_valid & ready_q;
  assign word_d = asm_q | (32'(byte_in) << {lane_q, 3'b000});

  // State and datapath registers; ready is registered so byte_valid never feeds it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
      ready_q <= 1'b0;
      core_q  <= 1'b0;
      err_q   <= 1'b0;
      wc_q    <= '0;
      lane_q  <= '0;
      asm_q   <= '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      cks_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != ST_RUN);
      core_q  <= (state_q == ST_RUN);
      err_q   <= err_d;
      wc_q    <= wc_d;
      lane_q  <= lane_d;
      asm_q   <= asm_d;
`ifdef IMEM_LOAD_CHECKSUM_EN
      cks_q   <= cks_d;
`endif
    end
  end

  // Next-state, byte assembly and word write control
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    wc_d    = wc_q;
    lane_d  = lane_q;
    asm_d   = asm_q;
    we      = 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
    cks_d   = cks_q;
`endif
    case (state_q)
      ST_LOAD: begin
        if (accept) begin
          if (wc_q == FULL_COUNT) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end else begin
`ifdef IMEM_LOAD_CHECKSUM_EN
            cks_d = cks_q ^ byte_in;
`endif
            if ((lane_q == 2'd3) || byte_last) begin
              we     = 1'b1;
              wc_d   = wc_q + 1'b1;
              lane_d = '0;
              asm_d  = '0;
            end else begin
              lane_d = lane_q + 1'b1;
              asm_d  = word_d;
            end
            if (byte_last) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
              state_d = ST_CKSUM;
`else
              state_d = ST_RUN;
`endif
            end
          end
        end
      end
      ST_CKSUM: begin
`ifdef IMEM_LOAD_CHECKSUM_EN
        if (accept) begin
          if (byte_in == cks_q) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end
        end
`else
        // Unreachable without the checksum feature; fail safe.
        state_d = ST_ERR;
        err_d   = 1'b1;
`endif
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_ERR;
        err_d   = 1'b1;
      end
    endcase
  end

  imem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .waddr (wc_q[AW-1:0]),
    .wdata (word_d),
    .raddr (rd_idx),
    .rdata (rd_word)
  );

  assign rd_idx           = IR_addr[AW+1:2];
  assign hi_zero          = (IR_addr[31:AW+2] == '0);
  assign unused_addr_bits = ^IR_addr[1:0];
  assign IR = (hi_zero && ({1'b0, rd_idx} < wc_q)) ? rd_word : NOP_WORD;

  assign byte_ready = ready_q;
  assign core_rst_n = core_q;
  assign word_count = wc_q;
  assign load_err   = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader with a word scoreboard.
module tb_imem_boot_loader;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_last;
  logic          byte_ready;
  logic [31:0]   IR_addr;
  logic [31:0]   IR;
  logic          core_rst_n;
  logic [AW:0]   word_count;
  logic          load_err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model of the load stream
  int          m_lane;
  logic [31:0] m_word;
  int          m_count;
  int          m_state;   // 0 load, 1 cksum, 2 run, 3 err
  logic [7:0]  m_xor;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  imem_boot_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_last  (byte_last),
    .byte_ready (byte_ready),
    .IR_addr    (IR_addr),
    .IR         (IR),
    .core_rst_n (core_rst_n),
    .word_count (word_count),
    .load_err   (load_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lane = 0; m_word = '0; m_count = 0; m_state = 0; m_xor = '0;
    exp_q.delete();
  endtask

  task automatic model_accept(input logic [7:0] b, input logic last);
    case (m_state)
      0: begin
        if (m_count == DEPTH) begin
          m_state = 3;
        end else begin
          m_xor  = m_xor ^ b;
          m_word = m_word | (32'(b) << (8 * m_lane));
          if (m_lane == 3 || last) begin
            exp_q.push_back(m_word);
            m_count++; m_lane = 0; m_word = '0;
          end else begin
            m_lane++;
          end
          if (last) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
            m_state = 1;
`else
            m_state = 2;
`endif
          end
        end
      end
      1: m_state = (b == m_xor) ? 2 : 3;
      default: ;
    endcase
  endtask

  // Reset for a few cycles, optionally holding byte_valid high throughout
  task automatic do_reset(input logic hold_valid);
    rst_n = 1'b0;
    byte_valid = hold_valid; byte_in = 8'hC3; byte_last = hold_valid;
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_ready", byte_ready, 0);
      check("rst_wc", word_count, 0);
    end
    check("rst_core", core_rst_n, 0);
    check("rst_err", load_err, 0);
    byte_valid = 1'b0; byte_last = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", byte_ready, 1);
    model_reset();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int t;
    byte_in = b; byte_last = last; byte_valid = 1'b1;
    t = 0;
    while (!byte_ready && t < 20) begin
      @(posedge clk); #1; t++;
    end
    check("hs_timeout", (t < 20), 1);
    @(posedge clk); #1;
    byte_valid = 1'b0; byte_last = 1'b0;
    model_accept(b, last);
  endtask

  // After the last payload byte: send checksum when enabled, then check release
  task automatic finish_and_expect_run();
`ifdef IMEM_LOAD_CHECKSUM_EN
    check("cksum_ready", byte_ready, 1);
    check("cksum_core", core_rst_n, 0);
    send_byte(m_xor, 1'b0);
`endif
    check("run_ready", byte_ready, 0);
    check("run_core_edge", core_rst_n, 0);
    check("run_err", load_err, 0);
    check("run_wc", word_count, 32'(m_count));
    @(posedge clk); #1;
    check("run_core", core_rst_n, 1);
  endtask

  task automatic readback();
    int i;
    logic [31:0] e;
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      IR_addr = 32'(i * 4) + 32'($urandom_range(0, 3));
      #1;
      check("ir_word", IR, e);
      i++;
    end
  endtask

  initial begin
    rst_n = 1'b0; byte_in = '0; byte_valid = 1'b0; byte_last = 1'b0; IR_addr = '0;
    model_reset();

    // Two-word program
    do_reset(1'b0);
    begin
      logic [7:0] s [8] = '{8'h13, 8'h00, 8'h08, 8'h20, 8'h2A, 8'h00, 8'h09, 8'h20};
      for (int k = 0; k < 8; k++) begin
        if (k == 5) begin
          IR_addr = 32'd0; #1;
          check("ir_during_load_w0", IR, 32'h2008_0013);
          IR_addr = 32'd4; #1;
          check("ir_during_load_w1", IR, 32'h0);
        end
        send_byte(s[k], k == 7);
      end
    end
    finish_and_expect_run();
    IR_addr = 32'd4; #1; check("ir_addr4", IR, 32'h2009_002A);
    IR_addr = 32'd5; #1; check("ir_addr5", IR, 32'h2009_002A);
    IR_addr = 32'd0; #1; check("ir_addr0", IR, 32'h2008_0013);
    IR_addr = 32'd8; #1; check("ir_addr8", IR, 32'h0);
    IR_addr = 32'h10; #1; check("ir_hi_bits", IR, 32'h0);
    readback();

    // byte_valid held in RUN: nothing accepted
    byte_valid = 1'b1; byte_in = 8'h55;
    repeat (4) begin
      @(posedge clk); #1;
      check("run_hold_ready", byte_ready, 0);
    end
    check("run_hold_wc", word_count, 2);
    byte_valid = 1'b0;

    // Reset with byte_valid held; stale words masked
    do_reset(1'b1);
    IR_addr = 32'd0; #1; check("stale_masked", IR, 32'h0);

    // Partial final word
    begin
      logic [7:0] s [5] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11};
      for (int k = 0; k < 5; k++) send_byte(s[k], k == 4);
    end
    finish_and_expect_run();
    IR_addr = 32'd4; #1; check("ir_partial", IR, 32'h0000_0011);
    IR_addr = 32'd8; #1; check("ir_past_partial", IR, 32'h0);
    readback();

    // Reset mid-load, then a one-word load
    do_reset(1'b0);
    for (int k = 0; k < 6; k++) send_byte(8'(8'h60 + k), 1'b0);
    check("midload_wc", word_count, 1);
    do_reset(1'b0);
    send_byte(8'h01, 1'b0); send_byte(8'h23, 1'b0);
    send_byte(8'h45, 1'b0); send_byte(8'h67, 1'b1);
    finish_and_expect_run();
    IR_addr = 32'd4; #1; check("reload_stale_w1", IR, 32'h0);
    IR_addr = 32'd0; #1; check("reload_w0", IR, 32'h6745_2301);
    readback();

    // Overflow: 17 bytes without last
    do_reset(1'b0);
    for (int k = 0; k < 16; k++) send_byte(8'($urandom_range(0, 255)), 1'b0);
    check("full_wc", word_count, 4);
    check("full_err", load_err, 0);
    send_byte(8'hEE, 1'b0);
    check("ovf_err", load_err, 1);
    check("ovf_ready", byte_ready, 1);
    check("ovf_core", core_rst_n, 0);
    check("ovf_wc", word_count, 4);
    send_byte(8'h77, 1'b1);
    repeat (2) @(posedge clk); #1;
    check("err_drain_ready", byte_ready, 1);
    check("err_sticky", load_err, 1);
    check("err_core", core_rst_n, 0);
    check("model_err", m_state, 3);
    readback();

    // byte_last on lane 0 with the array already full
    do_reset(1'b0);
    for (int k = 0; k < 16; k++) send_byte(8'(k), 1'b0);
    send_byte(8'h99, 1'b1);
    check("last_full_err", load_err, 1);
    check("last_full_ready", byte_ready, 1);
    check("last_full_wc", word_count, 4);
    @(posedge clk); #1;
    check("last_full_core", core_rst_n, 0);
    readback();

`ifdef IMEM_LOAD_CHECKSUM_EN
    // Checksum match
    do_reset(1'b0);
    send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0);
    send_byte(8'h04, 1'b0); send_byte(8'h08, 1'b1);
    check("ck_xor_model", m_xor, 8'h0F);
    check("ck_wait_ready", byte_ready, 1);
    send_byte(8'h0F, 1'b0);
    check("ck_ok_ready", byte_ready, 0);
    check("ck_ok_err", load_err, 0);
    @(posedge clk); #1;
    check("ck_ok_core", core_rst_n, 1);
    readback();

    // Checksum mismatch
    do_reset(1'b0);
    send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0);
    send_byte(8'h04, 1'b0); send_byte(8'h08, 1'b1);
    send_byte(8'h0E, 1'b0);
    check("ck_bad_err", load_err, 1);
    check("ck_bad_ready", byte_ready, 1);
    @(posedge clk); #1;
    check("ck_bad_core", core_rst_n, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
